// File: rtl/aes_vec_seq.sv
// aes_vec_seq: test-vector sequencer for aes_build.
// Holds NUM_VEC entries of {func, key, text, expected}. A run issues each entry
// to the AES core, waits for call_complete (or a timeout), compares the result
// against the expected value and tallies pass/fail. LOOP=1 replays the set forever.

module aes_vec_seq #(
    parameter int NUM_VEC = 8,
    parameter int KEY_W   = 256,
    parameter int TEXT_W  = 128,
    parameter int FUNC_W  = 3,
    parameter int TIMEOUT = 64,
    parameter int LOOP    = 0,
    localparam int IDX_W  = $clog2(NUM_VEC)
) (
    input  logic              eph1,
    input  logic              reset,
    input  logic              load_en,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic [FUNC_W-1:0] load_func,
    input  logic [KEY_W-1:0]  load_key,
    input  logic [TEXT_W-1:0] load_text,
    input  logic [TEXT_W-1:0] load_exp,
    input  logic              start,
    input  logic              abort,
    output logic [FUNC_W-1:0] func,
    output logic [TEXT_W-1:0] text_in,
    output logic [KEY_W-1:0]  true_key,
    output logic              req,
    input  logic              call_complete,
    input  logic [TEXT_W-1:0] ciphertext,
    input  logic [TEXT_W-1:0] plaintext,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  cur_idx,
    output logic [15:0]       pass_cnt,
    output logic [15:0]       fail_cnt,
    output logic [IDX_W-1:0]  first_fail_idx,
    output logic              first_fail_vld,
    output logic              timeout_err
);

    localparam int WCNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_VEC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t state;

    logic [FUNC_W-1:0] mem_func [NUM_VEC];
    logic [KEY_W-1:0]  mem_key  [NUM_VEC];
    logic [TEXT_W-1:0] mem_text [NUM_VEC];
    logic [TEXT_W-1:0] mem_exp  [NUM_VEC];

    logic [WCNT_W-1:0] wait_cnt;
    logic [TEXT_W-1:0] result_q;

    logic              idle_st;
    logic              last_idx;
    logic              timeout_hit;
    logic              check_pass;
    logic              tally_fail;
    logic              advance;
    logic [IDX_W-1:0]  nxt_idx;
    logic [FUNC_W-1:0] iss_func;
    logic [KEY_W-1:0]  iss_key;
    logic [TEXT_W-1:0] iss_text;

    assign busy = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_CHECK);

    // Vector storage: writable only while idle or done, never reset.
    always_ff @(posedge eph1) begin
        if (load_en && idle_st) begin
            mem_func[load_idx] <= load_func;
            mem_key[load_idx]  <= load_key;
            mem_text[load_idx] <= load_text;
            mem_exp[load_idx]  <= load_exp;
        end
    end

    // Event decode and selection of the entry to issue next; a load coinciding
    // with start is forwarded so the run sees the freshly written entry 0.
    always_comb begin
        idle_st     = (state == ST_IDLE) || (state == ST_DONE);
        last_idx    = (cur_idx == LAST_IDX);
        timeout_hit = (state == ST_WAIT) && !call_complete && (wait_cnt == WAIT_LIM);
        check_pass  = (state == ST_CHECK) && (result_q == mem_exp[cur_idx]);
        tally_fail  = timeout_hit || ((state == ST_CHECK) && !check_pass);
        advance     = timeout_hit || (state == ST_CHECK);
        if (idle_st || last_idx) begin
            nxt_idx = '0;
        end else begin
            nxt_idx = cur_idx + 1'b1;
        end
        iss_func = mem_func[nxt_idx];
        iss_key  = mem_key[nxt_idx];
        iss_text = mem_text[nxt_idx];
        if (idle_st && load_en && (load_idx == nxt_idx)) begin
            iss_func = load_func;
            iss_key  = load_key;
            iss_text = load_text;
        end
    end

    // Sequencer FSM with registered call interface, tallies and status flags.
    always_ff @(posedge eph1 or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            req            <= 1'b0;
            done           <= 1'b0;
            func           <= '0;
            text_in        <= '0;
            true_key       <= '0;
            cur_idx        <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
            timeout_err    <= 1'b0;
            wait_cnt       <= '0;
            result_q       <= '0;
        end else if (abort) begin
            state <= ST_IDLE;
            req   <= 1'b0;
            done  <= 1'b0;
        end else begin
            req <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        pass_cnt       <= '0;
                        fail_cnt       <= '0;
                        first_fail_vld <= 1'b0;
                        timeout_err    <= 1'b0;
                        done           <= 1'b0;
                        cur_idx        <= '0;
                        state          <= ST_ISSUE;
                        req            <= 1'b1;
                        func           <= iss_func;
                        text_in        <= iss_text;
                        true_key       <= iss_key;
                    end
                end
                ST_ISSUE: begin
                    state    <= ST_WAIT;
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    if (call_complete) begin
                        result_q <= func[0] ? ciphertext : plaintext;
                        state    <= ST_CHECK;
                    end else if (!timeout_hit) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase

            if (check_pass && (pass_cnt != 16'hFFFF)) begin
                pass_cnt <= pass_cnt + 16'd1;
            end
            if (tally_fail) begin
                if (fail_cnt != 16'hFFFF) begin
                    fail_cnt <= fail_cnt + 16'd1;
                end
                if (!first_fail_vld) begin
                    first_fail_idx <= cur_idx;
                    first_fail_vld <= 1'b1;
                end
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
            if (advance) begin
                if (!last_idx || (LOOP != 0)) begin
                    cur_idx  <= nxt_idx;
                    state    <= ST_ISSUE;
                    req      <= 1'b1;
                    func     <= iss_func;
                    text_in  <= iss_text;
                    true_key <= iss_key;
                end else begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/aes_vec_seq.md
Name: aes_vec_seq

Overview:
Parametrised, synthesizable test-vector sequencer for aes_build, for both sim and on-chip self-test.
- Holds NUM_VEC loadable entries of {func, key, text, expected}.
- Issues each entry to the AES core, waits for call_complete, and compares the result against the expected value.
- Tallies pass/fail and times out hung calls.
- LOOP mode replays the vector set indefinitely.

Parameters:
NUM_VEC, 8, number of vector entries (>=2)
KEY_W, 256, key field width (128/192/256 keys zero-extended on load)
TEXT_W, 128, text/result width
FUNC_W, 3, func code width; func[0]=1 means encrypt
TIMEOUT, 64, max eph1 cycles in WAIT before a call is declared hung
LOOP, 0, 1 = wrap to entry 0 after the last entry instead of stopping

Ports:
eph1  in  1  clock
reset  in  1  asynchronous, active-low reset
load_en  in  1  write one vector entry (accepted only in IDLE/DONE)
load_idx  in  $clog2(NUM_VEC)  entry index
load_func  in  FUNC_W  func code
load_key  in  KEY_W  key
load_text  in  TEXT_W  input text
load_exp  in  TEXT_W  expected result
start  in  1  begin a run at entry 0
abort  in  1  stop the run
func  out  FUNC_W  to aes_build.func
text_in  out  TEXT_W  to aes_build.text_in
true_key  out  KEY_W  to aes_build.true_key
req  out  1  one-cycle call pulse
call_complete  in  1  from aes_build
ciphertext  in  TEXT_W  from aes_build
plaintext  in  TEXT_W  from aes_build
busy  out  1  state is ISSUE, WAIT or CHECK
done  out  1  run finished (held)
cur_idx  out  $clog2(NUM_VEC)  entry in flight
pass_cnt  out  16  saturating pass count
fail_cnt  out  16  saturating fail count (includes timeouts)
first_fail_idx  out  $clog2(NUM_VEC)  index of the first failing entry
first_fail_vld  out  1  first_fail_idx is valid
timeout_err  out  1  sticky; set on any timeout

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including func, text_in, true_key, req and all counters/flags.
  - Vector memory contents are not reset.
- FSM states: IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE/DONE behaviour:
  - load_en writes entry load_idx on the eph1 edge.
  - start=1 moves to ISSUE and clears pass_cnt, fail_cnt, first_fail_vld, timeout_err and done; cur_idx=0.
  - load_en and start in the same cycle: the write lands first, then the run starts.
- Busy-state input handling:
  - load_en is ignored while busy.
  - start is ignored while busy.
- ISSUE (1 cycle):
  - req=1.
  - func/text_in/true_key are driven from entry cur_idx and stay stable through ISSUE, WAIT and CHECK.
  - Next state is WAIT; the wait counter is cleared.
- WAIT:
  - call_complete is sampled only in WAIT; a complete coinciding with req is ignored. Minimum issue-to-check latency is therefore 2 cycles.
  - call_complete=1: capture the result (ciphertext if func[0]=1, else plaintext), go to CHECK.
  - Wait counter reaches TIMEOUT-1 without complete: fail_cnt++, timeout_err=1, record first fail, then advance as CHECK does (skipping the compare).
  - call_complete on the same cycle as the timeout: the completion wins.
- CHECK (1 cycle):
  - Captured result == expected: pass_cnt++; otherwise fail_cnt++.
  - On the first fail of the run, first_fail_idx=cur_idx and first_fail_vld=1.
  - Then:
    - cur_idx < NUM_VEC-1: cur_idx++, go to ISSUE.
    - Else, LOOP=0: go to DONE, done=1.
    - Else, LOOP=1: cur_idx=0, go to ISSUE.
- Counters saturate at 16'hFFFF and never wrap.
- abort=1 in any state:
  - Next state is IDLE and req=0.
  - Counters and flags are held; done stays 0.
  - abort has priority over start and over all FSM transitions.
  - A late call_complete arriving after an abort is ignored.
- DONE holds done=1 and status until start or reset.

Test Plan:
1. Load entry 0 with func=3'h1, key=0x000102..0f (zero-extended), text=0x00112233445566778899aabbccddeeff, exp=0x69c4e0d86a7b0430d8cdb78070b4c55a; load entries 1-7 with valid vectors; start; model completes 10 cycles after req -> 8 req pulses, done=1, pass_cnt=8, fail_cnt=0, first_fail_vld=0.
2. Same set with entry 5's expected value bit-flipped -> pass_cnt=7, fail_cnt=1, first_fail_idx=5, first_fail_vld=1, timeout_err=0.
3. Model never completes entry 2 (TIMEOUT=64) -> WAIT exits exactly 64 cycles after entering WAIT; timeout_err=1, fail_cnt=1, first_fail_idx=2; run continues to done=1.
4. Decrypt entry with func=3'h2: model returns the correct plaintext and a garbage ciphertext -> pass; swap them -> fail.
5. abort during WAIT of entry 3 -> IDLE next cycle, pass_cnt=3 held, done=0; a late call_complete changes nothing; a new start clears the counters and reruns from entry 0.
6. LOOP=1, 2 runs of 8 vectors -> pass_cnt reaches 16 with done never set; reset=0 mid-WAIT -> all outputs are 0 immediately, without waiting for an eph1 edge.
